// File: rtl/inc16_arbiter.sv
// -----------------------------------------------------------------------------
// inc16_arbiter
//
// Shares one 16-bit incrementer (result = operand + 1, carry discarded) among
// NREQ requesters. Requesters are served round-robin through a valid/ready
// handshake. Each result, tagged with the index of its requester, is held in a
// single-entry output register that honours backpressure. A new result may
// replace a draining one on the same edge, so throughput is one result per
// cycle.
//
// Optional feature (compile-time macro INC16_ARBITER_OVF_FLAG_EN):
//   When defined, adds output rsp_ovf. It is registered alongside rsp_data and
//   is 1 when the accepted operand was 0xFFFF (carry out of bit 15).
//   When undefined, the port does not exist and the carry is dropped.
//
// Parameters:
//   NREQ  number of requesters (2..8)
//   IDW   width of the requester tag, equal to ceil(log2(NREQ))
//
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   req_valid  [NREQ]     requester i presents an operand
//   req_data   [16*NREQ]  operand of requester i at bits [16*i+15:16*i]
//   req_ready  [NREQ]     one-hot or zero; operand of requester i accepted
//   rsp_valid  result register holds a valid result
//   rsp_ready  consumer accepts the result this cycle
//   rsp_id     [IDW]      index of the requester that owns rsp_data
//   rsp_data   [16]       operand + 1, modulo 2^16
//   rsp_ovf    (optional) carry out of the accepted increment
//   busy       high whenever rsp_valid is high
// -----------------------------------------------------------------------------
module inc16_arbiter #(
  parameter int NREQ = 4,
  parameter int IDW  = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NREQ-1:0]   req_valid,
  input  logic [16*NREQ-1:0] req_data,
  output logic [NREQ-1:0]   req_ready,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [IDW-1:0]    rsp_id,
  output logic [15:0]       rsp_data,
`ifdef INC16_ARBITER_OVF_FLAG_EN
  output logic              rsp_ovf,
`endif
  output logic              busy
);

  // Catch a tag width that cannot address every requester, or that is wider
  // than necessary.
  if (NREQ < 2 || NREQ > 8 || IDW != $clog2(NREQ)) begin : g_param_check
    $error("inc16_arbiter: NREQ must be 2..8 and IDW must equal clog2(NREQ)");
  end

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_t;

  state_t          state;
  logic [IDW-1:0]  last_grant;

  logic            found;
  int              win_idx;
  int              cand;
  logic            slot_free;
  logic            accept;
  logic [IDW-1:0]  winner;
  logic [15:0]     operand;

  // ---------------------------------------------------------------------------
  // Round-robin search: start just after the last winner and wrap around, so
  // the most recently served requester has the lowest priority.
  // ---------------------------------------------------------------------------
  // NOTE: every variable assigned in always_comb gets a default value first,
  // so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    found   = 1'b0;
    win_idx = 0;
    cand    = 0;
    for (int off = 1; off <= NREQ; off++) begin
      cand = (int'(last_grant) + off) % NREQ;
      if (!found && req_valid[cand]) begin
        found   = 1'b1;
        win_idx = cand;
      end
    end
  end

  // The slot can take a new result if it is empty or is being drained now.
  assign slot_free = (state == EMPTY) || rsp_ready;

  // No grant is offered while reset is asserted, even though the slot is empty.
  assign accept    = rst_n && found && slot_free;
  assign req_ready = accept ? (NREQ'(1) << win_idx) : '0;

  assign winner  = IDW'(win_idx);
  assign operand = req_data[16*win_idx +: 16];

  assign rsp_valid = (state == FULL);
  assign busy      = rsp_valid;

  // ---------------------------------------------------------------------------
  // Result register and pointer. On acceptance, the new result replaces
  // whatever is in the slot. The slot can only be occupied here if it is also
  // draining this cycle, so no result is lost. Without acceptance, a drain
  // clears valid only; data, id and flag keep their values.
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of statement order.
`ifdef INC16_ARBITER_OVF_FLAG_EN
  logic [16:0] sum;
  assign sum = {1'b0, operand} + 17'd1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= EMPTY;
      rsp_id     <= '0;
      rsp_data   <= 16'h0000;
      rsp_ovf    <= 1'b0;
      last_grant <= IDW'(NREQ - 1);
    end else if (accept) begin
      state      <= FULL;
      rsp_id     <= winner;
      rsp_data   <= sum[15:0];
      rsp_ovf    <= sum[16];
      last_grant <= winner;
    end else if (state == FULL && rsp_ready) begin
      state      <= EMPTY;
    end
  end
`else
  logic [15:0] sum;
  assign sum = operand + 16'd1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= EMPTY;
      rsp_id     <= '0;
      rsp_data   <= 16'h0000;
      last_grant <= IDW'(NREQ - 1);
    end else if (accept) begin
      state      <= FULL;
      rsp_id     <= winner;
      rsp_data   <= sum;
      last_grant <= winner;
    end else if (state == FULL && rsp_ready) begin
      state      <= EMPTY;
    end
  end
`endif

endmodule

// File: tb/tb_inc16_arbiter.sv
// -----------------------------------------------------------------------------
// tb_inc16_arbiter
//
// Directed testbench for inc16_arbiter with NREQ=4 and IDW=2. Inputs are
// driven 1 time unit after a rising edge. Outputs are compared 2 units after
// that edge, well clear of the next one. Expected values are hand-computed.
// Define INC16_ARBITER_OVF_FLAG_EN to also cover rsp_ovf.
// -----------------------------------------------------------------------------
module tb_inc16_arbiter;

  localparam int NREQ = 4;
  localparam int IDW  = 2;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [NREQ-1:0]   req_valid;
  logic [16*NREQ-1:0] req_data;
  logic [NREQ-1:0]   req_ready;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [IDW-1:0]    rsp_id;
  logic [15:0]       rsp_data;
  logic              busy;
`ifdef INC16_ARBITER_OVF_FLAG_EN
  logic              rsp_ovf;
`endif

  int n_cmp = 0;
  int n_err = 0;

  inc16_arbiter #(.NREQ(NREQ), .IDW(IDW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_data  (req_data),
    .req_ready (req_ready),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_id    (rsp_id),
    .rsp_data  (rsp_data),
`ifdef INC16_ARBITER_OVF_FLAG_EN
    .rsp_ovf   (rsp_ovf),
`endif
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance to 1 unit after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_data(input int i, input logic [15:0] v);
    req_data[16*i +: 16] = v;
  endtask

  task automatic check_rsp(input string tag, input logic [IDW-1:0] id, input logic [15:0] data);
    check({tag, "_valid"}, 32'(rsp_valid), 32'd1);
    check({tag, "_busy"},  32'(busy),      32'd1);
    check({tag, "_id"},    32'(rsp_id),    32'(id));
    check({tag, "_data"},  32'(rsp_data),  32'(data));
  endtask

  logic [15:0] rr_op  [4] = '{16'hFFFB, 16'h0005, 16'h1234, 16'h7FFF};
  logic [15:0] rr_res [4] = '{16'hFFFC, 16'h0006, 16'h1235, 16'h8000};

  initial begin
    rst_n     = 1'b0;
    req_valid = '0;
    req_data  = '0;
    rsp_ready = 1'b0;

    // Reset state, with a request present to show grants are suppressed.
    req_valid = 4'b0001;
    #2;
    check("rst_ready", 32'(req_ready), 32'h0);
    check("rst_valid", 32'(rsp_valid), 32'h0);
    check("rst_busy",  32'(busy),      32'h0);
    check("rst_id",    32'(rsp_id),    32'h0);
    check("rst_data",  32'(rsp_data),  32'h0);
`ifdef INC16_ARBITER_OVF_FLAG_EN
    check("rst_ovf",   32'(rsp_ovf),   32'h0);
`endif
    tick();
    tick();

    // 1. First request after reset: requester 0 has priority.
    rst_n = 1'b1;
    req_valid = 4'b0001;
    set_data(0, 16'h0000);
    #1;
    check("t1_ready", 32'(req_ready), 32'b0001);
    tick();
    req_valid = 4'b0000;
    #1;
    check_rsp("t1", 2'd0, 16'h0001);

    // 2. Wrap-around: 0xFFFF -> 0x0000, then 0x0005 -> 0x0006.
    rsp_ready = 1'b1;
    req_valid = 4'b0100;
    set_data(2, 16'hFFFF);
    #1;
    check("t2_ready", 32'(req_ready), 32'b0100);
    tick();
    set_data(2, 16'h0005);
    #1;
    check_rsp("t2_wrap", 2'd2, 16'h0000);
`ifdef INC16_ARBITER_OVF_FLAG_EN
    check("t2_ovf1", 32'(rsp_ovf), 32'h1);
`endif
    check("t2_ready2", 32'(req_ready), 32'b0100);
    tick();
    req_valid = 4'b1000;
    set_data(3, 16'h0010);
    #1;
    check_rsp("t2_next", 2'd2, 16'h0006);
`ifdef INC16_ARBITER_OVF_FLAG_EN
    check("t2_ovf0", 32'(rsp_ovf), 32'h0);
`endif
    // Pointer 2 -> search 3 first; this moves the pointer to 3.
    check("t2_ready3", 32'(req_ready), 32'b1000);
    tick();
    req_valid = 4'b0000;
    #1;
    check_rsp("t2_r3", 2'd3, 16'h0011);

    // 3. Round-robin with all requesters active and no bubbles.
    req_valid = 4'b1111;
    for (int i = 0; i < 4; i++) set_data(i, rr_op[i]);
    for (int k = 0; k < 4; k++) begin
      #1;
      check($sformatf("t3_ready%0d", k), 32'(req_ready), 32'(1) << k);
      tick();
      if (k == 3) req_valid = 4'b0000;
      #1;
      check_rsp($sformatf("t3_rsp%0d", k), IDW'(k), rr_res[k]);
    end

    // 4. Backpressure: hold 0x0006 from requester 1.
    req_valid = 4'b0010;
    set_data(1, 16'h0005);
    #1;
    check("t4_ready", 32'(req_ready), 32'b0010);
    tick();
    rsp_ready = 1'b0;
    req_valid = 4'b0011;
    set_data(0, 16'h00AA);
    for (int k = 0; k < 3; k++) begin
      #1;
      check($sformatf("t4_bp_ready%0d", k), 32'(req_ready), 32'h0);
      check_rsp($sformatf("t4_bp%0d", k), 2'd1, 16'h0006);
      tick();
    end
    // Consumer accepts: next requester after 1 with a request is 0.
    rsp_ready = 1'b1;
    #1;
    check("t4_release_ready", 32'(req_ready), 32'b0001);
    tick();
    req_valid = 4'b0000;
    #1;
    check_rsp("t4_after", 2'd0, 16'h00AB);

    // 5. Reset mid-operation while holding 0x1235.
    req_valid = 4'b0100;
    set_data(2, 16'h1234);
    #1;
    check("t5_ready", 32'(req_ready), 32'b0100);
    tick();
    req_valid = 4'b0000;
    rsp_ready = 1'b0;
    #1;
    check_rsp("t5_held", 2'd2, 16'h1235);
    rst_n = 1'b0;
    #1;
    check("t5_rst_valid", 32'(rsp_valid), 32'h0);
    check("t5_rst_busy",  32'(busy),      32'h0);
    check("t5_rst_data",  32'(rsp_data),  32'h0);
    check("t5_rst_id",    32'(rsp_id),    32'h0);
    tick();
    rst_n = 1'b1;
    rsp_ready = 1'b1;
    req_valid = 4'b1100;
    set_data(2, 16'h0100);
    set_data(3, 16'h0200);
    #1;
    check("t5_post_ready", 32'(req_ready), 32'b0100);
    tick();
    // 6. Idle pointer hold: grant requester 1, idle, then 0 wins over 1.
    req_valid = 4'b0010;
    set_data(1, 16'h0300);
    #1;
    check_rsp("t5_post", 2'd2, 16'h0101);
    check("t6_ready1", 32'(req_ready), 32'b0010);
    tick();
    req_valid = 4'b0000;
    #1;
    check_rsp("t6_r1", 2'd1, 16'h0301);
    tick();
    #1;
    check("t6_drain_valid", 32'(rsp_valid), 32'h0);
    check("t6_drain_data",  32'(rsp_data),  32'h0301);
    check("t6_drain_id",    32'(rsp_id),    32'h1);
    for (int k = 0; k < 4; k++) tick();
    req_valid = 4'b0011;
    set_data(0, 16'h0400);
    #1;
    check("t6_ready0", 32'(req_ready), 32'b0001);
    tick();
    req_valid = 4'b0000;
    #1;
    check_rsp("t6_r0", 2'd0, 16'h0401);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/inc16_arbiter.md
Name: inc16_arbiter

Overview:
- Shares one 16-bit incrementer datapath (out = in + 1, carry discarded) among NREQ requesters.
- Each requester presents an operand with a valid/ready handshake. The block arbitrates round-robin, computes the increment, and returns the result tagged with the requester index through a single-entry output register with backpressure.
- Sits between the register/PC-style clients and the shared incrementer in the ALU-side datapath.

Parameters:
- NREQ, 4, number of requesters (2..8).
- IDW, 2, width of the requester-index tag; must equal ceil(log2(NREQ)).

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous, active-low reset.
- req_valid  input  NREQ  requester i presents an operand.
- req_data  input  16*NREQ  operand of requester i, at bits [16*i+15:16*i].
- req_ready  output  NREQ  one-hot (or zero); operand of requester i is accepted this cycle.
- rsp_valid  output  1  result register holds a valid result.
- rsp_ready  input  1  consumer accepts the result this cycle.
- rsp_id  output  IDW  index of the requester that owns rsp_data.
- rsp_data  output  16  operand + 1, modulo 2^16.
- busy  output  1  high whenever rsp_valid is high.

Behaviour:
- **Reset (async, rst_n low):**
  - rsp_valid=0, rsp_id=0, rsp_data=0x0000, busy=0.
  - Round-robin pointer last_grant = NREQ-1, so requester 0 has first priority.
  - req_ready is all zeros while rst_n is low.
- **States:**
  - EMPTY: rsp_valid=0.
  - FULL: rsp_valid=1.
- **slot_free** = EMPTY, or (FULL and rsp_ready). This is combinational.
- **Arbitration (combinational):**
  - Search req_valid starting at index last_grant+1, wrapping past NREQ-1 to 0. The first set bit is the winner.
  - req_ready[winner]=1 only if slot_free; all other req_ready bits are 0.
  - If no req_valid bit is set, req_ready is all zeros.
- **Acceptance** occurs on a clock edge where req_valid[w] and req_ready[w] are both high. On that edge:
  - rsp_data <= req_data[w] + 1, truncated to 16 bits.
  - rsp_id <= w.
  - rsp_valid <= 1.
  - last_grant <= w.
- **Latency:** the result is visible on the cycle after acceptance, a fixed 1 cycle.
- **Drain:** on an edge with FULL, rsp_ready=1 and no acceptance, rsp_valid <= 0 and rsp_data/rsp_id hold their values.
- **Simultaneous drain and accept:** the new result replaces the old one with no bubble. rsp_valid stays 1, giving full throughput of 1 result per cycle.
- **Backpressure:**
  - FULL with rsp_ready=0 means all req_ready bits are 0.
  - rsp_data and rsp_id stay stable while rsp_valid=1 and rsp_ready=0.
- **Pointer:** last_grant updates only on acceptance, never on idle cycles.
- **Fairness:** a requester holding req_valid high is granted within NREQ accepted transactions.
- **Wrap-around:**
  - Operand 0xFFFF produces 0x0000.
  - Operand 0xFFFB produces 0xFFFC.
- **Reset mid-operation:** any held result is discarded immediately, with no response emitted, and the pointer returns to NREQ-1.
- **Requester obligation:** req_data must be stable while req_valid is high and not yet accepted. The block does not check this.

Optional Feature:
- Macro: INC16_ARBITER_OVF_FLAG_EN.
- **Defined:**
  - Adds output port rsp_ovf (1 bit), registered alongside rsp_data.
  - rsp_ovf=1 when the accepted operand was 0xFFFF (carry out of bit 15), otherwise 0.
  - rsp_ovf resets to 0 and holds under backpressure like rsp_data.
- **Undefined:** the port does not exist and the carry is silently discarded. All other behaviour is identical.

Test Plan:
1. Reset then single request: rst_n low for 2 cycles, then req_valid=0001 with req_data[0]=0x0000 → req_ready=0001 that cycle; next cycle rsp_valid=1, rsp_id=0, rsp_data=0x0001.
2. Wrap: requester 2 sends 0xFFFF → rsp_data=0x0000, rsp_id=2. With INC16_ARBITER_OVF_FLAG_EN, rsp_ovf=1. A following operand of 0x0005 gives 0x0006 with rsp_ovf=0.
3. Round-robin: req_valid=1111 held for 4 cycles with rsp_ready=1 and operands 0xFFFB, 0x0005, 0x1234, 0x7FFF → grants 0,1,2,3 in order and responses 0xFFFC, 0x0006, 0x1235, 0x8000 on consecutive cycles with no bubble.
4. Backpressure: result 0x0006 held with rsp_ready=0 for 3 cycles while req_valid=0011 → req_ready=00, rsp_data/rsp_id stable. On the cycle rsp_ready rises, the next requester is granted in the same cycle.
5. Reset mid-operation: rsp_valid=1 with rsp_data=0x1235, rst_n pulsed low asynchronously between edges → rsp_valid=0 and rsp_data=0x0000 immediately. After release with req_valid=1100, requester 2 is granted first.
6. Idle pointer hold: after granting requester 1, 5 idle cycles, then req_valid=0011 → requester 0 is granted (pointer unchanged at 1, search starts at 2 and wraps to 0).
